// File: rtl/nv_pg_pkg.sv
// nv_pg_pkg: shared definitions for the nv_pg_seq power-gating sequencer.
//   - pg_state_e : 10-state sequencer encoding (4-bit)
//   - pg_out_t   : Moore output vector, one field per sequencer output
//   - OUT_*      : per-state output constants, st_out() decodes a state
package nv_pg_pkg;

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_CLK_OFF = 4'd1,
    ST_ISO_ON  = 4'd2,
    ST_SAVE    = 4'd3,
    ST_SW_OFF  = 4'd4,
    ST_OFF     = 4'd5,
    ST_SW_ON   = 4'd6,
    ST_RESTORE = 4'd7,
    ST_ISO_OFF = 4'd8,
    ST_CLK_ON  = 4'd9
  } pg_state_e;

  typedef struct packed {
    logic clk_en;
    logic iso_en;
    logic sw_en;
    logic ret_save;
    logic ret_restore;
    logic rst_dom;
    logic pg_ack;
    logic busy;
  } pg_out_t;

  localparam pg_out_t OUT_ON      = 8'b1010_0000;
  localparam pg_out_t OUT_CLK_OFF = 8'b0010_0001;
  localparam pg_out_t OUT_ISO_ON  = 8'b0110_0001;
  localparam pg_out_t OUT_SAVE    = 8'b0111_0001;
  localparam pg_out_t OUT_SW_OFF  = 8'b0100_0001;
  localparam pg_out_t OUT_OFF     = 8'b0100_0010;
  localparam pg_out_t OUT_SW_ON   = 8'b0110_0111;
  localparam pg_out_t OUT_RESTORE = 8'b0110_1011;
  localparam pg_out_t OUT_ISO_OFF = 8'b0010_0011;
  localparam pg_out_t OUT_CLK_ON  = 8'b1010_0011;

  function automatic pg_out_t st_out(input pg_state_e s);
    case (s)
      ST_ON:      return OUT_ON;
      ST_CLK_OFF: return OUT_CLK_OFF;
      ST_ISO_ON:  return OUT_ISO_ON;
      ST_SAVE:    return OUT_SAVE;
      ST_SW_OFF:  return OUT_SW_OFF;
      ST_OFF:     return OUT_OFF;
      ST_SW_ON:   return OUT_SW_ON;
      ST_RESTORE: return OUT_RESTORE;
      ST_ISO_OFF: return OUT_ISO_OFF;
      ST_CLK_ON:  return OUT_CLK_ON;
      default:    return OUT_ON;
    endcase
  endfunction

endpackage

// File: rtl/nv_pg_cnt.sv
// nv_pg_cnt: step/timeout counter for nv_pg_seq.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : return count to 0 (wins over en_i)
//   en_i         : increment
//   lim_i        : limit (held stable by the parent)
//   hit_o        : count equals limit
module nv_pg_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] lim_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign hit_o = (cnt_q == lim_i);

endmodule

// File: rtl/nv_pg_seq.sv
// nv_pg_seq: power-gating sequencer for one switchable partition (always-on).
//   pg_req=1 runs clock-off, isolate, retention save, switch-off; pg_req=0
//   runs the mirrored power-up. pg_ack reports the settled state.
// Ports:
//   nvdla_core_clk/nvdla_core_rst : clock, synchronous active-high reset
//   pg_req / pg_ack / busy        : request level, settled state, in-progress
//   cfg_step_dly / cfg_sw_timeout : dwell D (D+1 cycles), switch timeout T
//   sw_en / sw_ack                : switch-chain enable and end-of-chain feedback
//   clk_en iso_en ret_save ret_restore rst_dom : partition controls
//   err / err_clr                 : sticky switch-timeout flag and its clear
module nv_pg_seq
  import nv_pg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             pg_req,
  output logic             pg_ack,
  output logic             busy,
  input  logic [CNT_W-1:0] cfg_step_dly,
  input  logic [CNT_W-1:0] cfg_sw_timeout,
  output logic             sw_en,
  input  logic             sw_ack,
  output logic             clk_en,
  output logic             iso_en,
  output logic             ret_save,
  output logic             ret_restore,
  output logic             rst_dom,
  output logic             err,
  input  logic             err_clr
);

  pg_state_e        state_q, state_d;
  pg_out_t          out_q;
  logic             err_q, err_d, err_set;
  logic [CNT_W-1:0] dly_q, to_q, lim;
  logic             hit, cnt_clr, cnt_en, idle, leave_idle, sw_wait;

  assign idle       = (state_q == ST_ON) || (state_q == ST_OFF);
  assign sw_wait    = (state_q == ST_SW_OFF) || (state_q == ST_SW_ON);
  // Counter restarts on every state change, so each state sees 0 on entry.
  assign cnt_clr    = (state_d != state_q);
  assign cnt_en     = !idle;
  assign leave_idle = idle && cnt_clr;
  assign lim        = sw_wait ? to_q : dly_q;

  nv_pg_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i (nvdla_core_clk),
    .rst_i (nvdla_core_rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .lim_i (lim),
    .hit_o (hit)
  );

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      ST_ON:      if (pg_req) state_d = ST_CLK_OFF;
      ST_CLK_OFF: if (hit)    state_d = ST_ISO_ON;
      ST_ISO_ON:  if (hit)    state_d = ST_SAVE;
      ST_SAVE:    if (hit)    state_d = ST_SW_OFF;
      // Matching ack is checked first so it wins over a same-cycle timeout.
      ST_SW_OFF: begin
        if (!sw_ack)  state_d = ST_OFF;
        else if (hit) begin
          state_d = ST_OFF;
          err_set = 1'b1;
        end
      end
      ST_OFF:     if (!pg_req) state_d = ST_SW_ON;
      ST_SW_ON: begin
        if (sw_ack)   state_d = ST_RESTORE;
        else if (hit) begin
          state_d = ST_RESTORE;
          err_set = 1'b1;
        end
      end
      ST_RESTORE: if (hit) state_d = ST_ISO_OFF;
      ST_ISO_OFF: if (hit) state_d = ST_CLK_ON;
      ST_CLK_ON:  if (hit) state_d = ST_ON;
      default:             state_d = ST_ON;
    endcase
    // Set wins over a same-cycle clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  // Outputs are registered from the next state so they move with state_q.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= ST_ON;
      out_q   <= OUT_ON;
      err_q   <= 1'b0;
      dly_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= st_out(state_d);
      err_q   <= err_d;
      // Config is frozen for the whole sequence.
      if (leave_idle) begin
        dly_q <= cfg_step_dly;
        to_q  <= cfg_sw_timeout;
      end
    end
  end

  assign clk_en      = out_q.clk_en;
  assign iso_en      = out_q.iso_en;
  assign sw_en       = out_q.sw_en;
  assign ret_save    = out_q.ret_save;
  assign ret_restore = out_q.ret_restore;
  assign rst_dom     = out_q.rst_dom;
  assign pg_ack      = out_q.pg_ack;
  assign busy        = out_q.busy;
  assign err         = err_q;

endmodule

// File: tb/tb_nv_pg_seq.sv
// tb_nv_pg_seq: directed bench for nv_pg_seq. Expected per-cycle output
// vectors {clk_en,iso_en,sw_en,ret_save,ret_restore,rst_dom,pg_ack,busy,err}
// are queued from the sequence timing, then popped one per clock.
module tb_nv_pg_seq;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst, pg_req, pg_ack, busy, sw_en, sw_ack, clk_en, iso_en;
  logic ret_save, ret_restore, rst_dom, err, err_clr;
  logic [CNT_W-1:0] cfg_step_dly, cfg_sw_timeout;

  always #5 clk = ~clk;

  nv_pg_seq #(.CNT_W(CNT_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .pg_req         (pg_req),
    .pg_ack         (pg_ack),
    .busy           (busy),
    .cfg_step_dly   (cfg_step_dly),
    .cfg_sw_timeout (cfg_sw_timeout),
    .sw_en          (sw_en),
    .sw_ack         (sw_ack),
    .clk_en         (clk_en),
    .iso_en         (iso_en),
    .ret_save       (ret_save),
    .ret_restore    (ret_restore),
    .rst_dom        (rst_dom),
    .err            (err),
    .err_clr        (err_clr)
  );

  // Switch-chain model: 3-cycle follower, stuck high, or direct copy.
  localparam int M_DLY3 = 0, M_STUCK1 = 1, M_COMB = 2;
  int mode = M_DLY3;
  logic [2:0] ack_pipe = 3'b111;
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], sw_en};
  assign sw_ack = (mode == M_COMB) ? sw_en : (mode == M_STUCK1) ? 1'b1 : ack_pipe[2];

  // Output vectors straight from the state table.
  localparam logic [7:0] V_ON      = 8'b1010_0000;
  localparam logic [7:0] V_CLK_OFF = 8'b0010_0001;
  localparam logic [7:0] V_ISO_ON  = 8'b0110_0001;
  localparam logic [7:0] V_SAVE    = 8'b0111_0001;
  localparam logic [7:0] V_SW_OFF  = 8'b0100_0001;
  localparam logic [7:0] V_OFF     = 8'b0100_0010;
  localparam logic [7:0] V_SW_ON   = 8'b0110_0111;
  localparam logic [7:0] V_RESTORE = 8'b0110_1011;
  localparam logic [7:0] V_ISO_OFF = 8'b0010_0011;
  localparam logic [7:0] V_CLK_ON  = 8'b1010_0011;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [7:0] v, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({v, e});
      tag_q.push_back(t);
    end
  endtask

  task automatic push_down(input int d, input int w, input logic e0, input logic e1);
    push("clk_off", V_CLK_OFF, e0, d + 1);
    push("iso_on",  V_ISO_ON,  e0, d + 1);
    push("save",    V_SAVE,    e0, d + 1);
    push("sw_off",  V_SW_OFF,  e0, w);
    push("off",     V_OFF,     e1, 1);
  endtask

  task automatic push_up(input int d, input int w, input logic e0, input logic e1);
    push("sw_on",   V_SW_ON,   e0, w);
    push("restore", V_RESTORE, e0, d + 1);
    push("iso_off", V_ISO_OFF, e0, d + 1);
    push("clk_on",  V_CLK_ON,  e0, d + 1);
    push("on",      V_ON,      e1, 1);
  endtask

  // One clock per queued entry; optional pg_req toggling, err_clr pulse at
  // clr_idx and a cfg_step_dly change at cfg_idx (applied before that edge).
  task automatic drain(input bit tog, input int clr_idx, input int cfg_idx);
    logic [8:0] obs, expv;
    string t;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      err_clr = (i == clr_idx);
      if (tog && i > 0) pg_req = ~pg_req;
      if (i == cfg_idx) cfg_step_dly = 8'd7;
      step();
      obs  = {clk_en, iso_en, sw_en, ret_save, ret_restore, rst_dom, pg_ack, busy, err};
      expv = exp_q.pop_front();
      t    = tag_q.pop_front();
      n_chk++;
      assert (obs === expv) else begin
        n_fail++;
        $error("FAIL %s step %0d: observed %b expected %b", t, i, obs, expv);
      end
      i++;
    end
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pg_req = 1'b0; err_clr = 1'b0;
    cfg_step_dly = 8'd2; cfg_sw_timeout = 8'd10; mode = M_DLY3;

    // Reset values
    step(); step();
    push("reset", V_ON, 1'b0, 1);
    drain(1'b0, -1, -1);
    rst = 1'b0;

    // D=2, T=10, ack follows sw_en by 3 cycles: down then up
    pg_req = 1'b1;
    push_down(2, 4, 1'b0, 1'b0);
    push("off_hold", V_OFF, 1'b0, 2);
    drain(1'b0, -1, -1);
    pg_req = 1'b0;
    push_up(2, 4, 1'b0, 1'b0);
    drain(1'b0, -1, -1);

    // T=5, ack stuck high in SW_OFF: timeout after 6 cycles sets err
    cfg_step_dly = 8'd0; cfg_sw_timeout = 8'd5; mode = M_STUCK1;
    pg_req = 1'b1;
    push_down(0, 6, 1'b0, 1'b1);
    drain(1'b0, -1, -1);
    push("err_clr", V_OFF, 1'b0, 1);
    drain(1'b0, 0, -1);
    pg_req = 1'b0;
    push_up(0, 1, 1'b0, 1'b0);
    drain(1'b0, -1, -1);
    // err_clr on the timeout edge: set wins
    pg_req = 1'b1;
    push_down(0, 6, 1'b0, 1'b1);
    drain(1'b0, 9, -1);
    push("err_clr2", V_OFF, 1'b0, 1);
    drain(1'b0, 0, -1);
    pg_req = 1'b0;
    push_up(0, 1, 1'b0, 1'b0);
    drain(1'b0, -1, -1);

    // pg_req toggling and cfg change mid-sequence are ignored
    cfg_step_dly = 8'd1; cfg_sw_timeout = 8'd10; mode = M_COMB;
    pg_req = 1'b1;
    push_down(1, 1, 1'b0, 1'b0);
    drain(1'b1, -1, 2);
    pg_req = 1'b1;
    push("off_req1", V_OFF, 1'b0, 2);
    drain(1'b0, -1, -1);
    cfg_step_dly = 8'd1;
    pg_req = 1'b0;
    push_up(1, 1, 1'b0, 1'b0);
    drain(1'b0, -1, -1);

    // Reset while in SAVE
    cfg_step_dly = 8'd2; mode = M_DLY3;
    pg_req = 1'b1;
    push("clk_off", V_CLK_OFF, 1'b0, 3);
    push("iso_on",  V_ISO_ON,  1'b0, 3);
    push("save",    V_SAVE,    1'b0, 1);
    drain(1'b0, -1, -1);
    rst = 1'b1; pg_req = 1'b0;
    push("rst_in_save", V_ON, 1'b0, 1);
    drain(1'b0, -1, -1);
    rst = 1'b0;

    // D=0, T=0, ack is a direct copy: 5+5 cycles, ack beats timeout
    cfg_step_dly = 8'd0; cfg_sw_timeout = 8'd0; mode = M_COMB;
    push("idle_on", V_ON, 1'b0, 1);
    drain(1'b0, -1, -1);
    pg_req = 1'b1;
    push_down(0, 1, 1'b0, 1'b0);
    drain(1'b0, -1, -1);
    pg_req = 1'b0;
    push_up(0, 1, 1'b0, 1'b0);
    drain(1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
